// File: rtl/tt_um_restoring_divider_pkg.sv
// Shared types and constants for the restoring divider.
// It holds the FSM state encoding, the datapath widths and a single-iteration step function.
package tt_um_restoring_divider_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int ITERS      = 8;
    localparam int ACC_W      = DIVISOR_W + 1;
    localparam int CNT_W      = $clog2(ITERS);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic             q_bit;
    } step_t;

    // One restoring step: shift the next dividend bit into the partial remainder,
    // then subtract the divisor when it fits. A zero divisor always "fits", so the
    // quotient saturates to all ones and the accumulator keeps the raw dividend bits.
    function automatic step_t div_step(input logic [ACC_W-1:0]     acc,
                                       input logic                 in_bit,
                                       input logic [DIVISOR_W-1:0] dvs);
        logic [ACC_W-1:0] shifted;
        step_t            res;
        shifted = {acc[ACC_W-2:0], in_bit};
        if (shifted >= {1'b0, dvs}) begin
            res.acc   = shifted - {1'b0, dvs};
            res.q_bit = 1'b1;
        end else begin
            res.acc   = shifted;
            res.q_bit = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/tt_um_restoring_divider_core.sv
// Restoring-division datapath and IDLE/RUN/DONE sequencer.
// The block produces one quotient bit per enabled clock and leaves the result in DONE.
module div_core
    import tt_um_restoring_divider_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  dbz,
    output logic                  busy,
    output logic                  done
);

    state_t                state;
    logic                  start_q;
    logic                  start_edge;
    logic [DIVIDEND_W-1:0] dvd_sr;
    logic [DIVISOR_W-1:0]  dvs_r;
    logic [ACC_W-1:0]      acc;
    logic [CNT_W-1:0]      cnt;
    step_t                 step;

    assign start_edge = start & ~start_q;

    always_comb begin
        step = div_step(acc, dvd_sr[DIVIDEND_W-1], dvs_r);
    end

    // start_q advances only with en, so edges that occur while disabled are lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            dvd_sr    <= '0;
            dvs_r     <= '0;
            acc       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (en) begin
            start_q <= start;
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        dvd_sr   <= dividend;
                        dvs_r    <= divisor;
                        acc      <= '0;
                        cnt      <= '0;
                        quotient <= '0;
                        dbz      <= (divisor == '0);
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc      <= step.acc;
                    dvd_sr   <= {dvd_sr[DIVIDEND_W-2:0], 1'b0};
                    quotient <= {quotient[DIVIDEND_W-2:0], step.q_bit};
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        remainder <= step.acc[DIVISOR_W-1:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/tt_um_restoring_divider.sv
// Pin wrapper: maps the tile pins onto div_core and selects quotient or status/remainder.
// uio[7:6] are fixed outputs (done, busy); the rest of uio carries inputs.
module tt_um_restoring_divider
    import tt_um_restoring_divider_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  dbz;
    logic                  busy;
    logic                  done;
    logic                  rsel;
    logic                  unused_bits;

    assign rsel        = uio_in[5];
    assign unused_bits = &{1'b0, uio_in[7:6]};

    div_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (ena),
        .start     (uio_in[4]),
        .dividend  (ui_in),
        .divisor   (uio_in[3:0]),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .busy      (busy),
        .done      (done)
    );

    assign uo_out  = rsel ? {dbz, 3'b000, remainder} : quotient;
    assign uio_out = {done, busy, 6'b00_0000};
    assign uio_oe  = 8'b1100_0000;

endmodule

// File: tb/tb_tt_um_restoring_divider.sv
// Directed bench for tt_um_restoring_divider; expected results are hand-computed.
module tb_tt_um_restoring_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic [3:0] dvs = '0;
    logic       start = 1'b0;
    logic       rsel = 1'b0;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_err = 0;

    // bits [7:6] are driven high to show they are ignored
    assign uio_in = {2'b11, rsel, start, dvs};

    always #5 clk = ~clk;

    tt_um_restoring_divider dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    // Pulse start for one clock; returns at the negedge after the capture edge E0.
    task automatic start_op(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        ui_in = a;
        dvs   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedge samples with busy high (bounded).
    task automatic wait_busy(output int cycles);
        cycles = 0;
        while (uio_out[6] === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (uo_out !== 8'h00) begin n_err++; $display("FAIL reset_uo_out got %h want 00", uo_out); end
        n_cmp++;
        if (uio_out !== 8'h00) begin n_err++; $display("FAIL reset_uio_out got %h want 00", uio_out); end
        n_cmp++;
        if (uio_oe !== 8'hC0) begin n_err++; $display("FAIL uio_oe got %h want c0", uio_oe); end
        rsel = 1'b1;
        #1;
        n_cmp++;
        if (uo_out !== 8'h00) begin n_err++; $display("FAIL reset_rem got %h want 00", uo_out); end
        rsel = 1'b0;
    endtask

    task automatic test_division;
        logic [7:0] ta [6] = '{8'd200, 8'd255, 8'd7, 8'd144, 8'd99, 8'd13};
        logic [3:0] tb [6] = '{4'd7,   4'd1,   4'd9, 4'd12,  4'd10, 4'd15};
        logic [7:0] tq [6] = '{8'd28,  8'd255, 8'd0, 8'd12,  8'd9,  8'd0};
        logic [7:0] tr [6] = '{8'h04,  8'h00,  8'h07, 8'h00, 8'h09, 8'h0D};
        int n;
        for (int i = 0; i < 6; i++) begin
            start_op(ta[i], tb[i]);
            wait_busy(n);
            n_cmp++;
            if (n != 8) begin n_err++; $display("FAIL div%0d_busy_cycles got %0d want 8", i, n); end
            n_cmp++;
            if (uio_out !== 8'h80) begin n_err++; $display("FAIL div%0d_done got %h want 80", i, uio_out); end
            n_cmp++;
            if (uo_out !== tq[i]) begin n_err++; $display("FAIL div%0d_quot got %0d want %0d", i, uo_out, tq[i]); end
            rsel = 1'b1;
            #1;
            n_cmp++;
            if (uo_out !== tr[i]) begin n_err++; $display("FAIL div%0d_rem got %h want %h", i, uo_out, tr[i]); end
            rsel = 1'b0;
        end
    endtask

    task automatic test_div_by_zero;
        int n;
        start_op(8'd5, 4'd0);
        wait_busy(n);
        n_cmp++;
        if (n != 8) begin n_err++; $display("FAIL dbz_busy_cycles got %0d want 8", n); end
        n_cmp++;
        if (uo_out !== 8'hFF) begin n_err++; $display("FAIL dbz_quot got %h want ff", uo_out); end
        rsel = 1'b1;
        #1;
        n_cmp++;
        if (uo_out !== 8'h85) begin n_err++; $display("FAIL dbz_rem got %h want 85", uo_out); end
        rsel = 1'b0;
        // dbz must clear on the next start
        start_op(8'd13, 4'd15);
        wait_busy(n);
        rsel = 1'b1;
        #1;
        n_cmp++;
        if (uo_out !== 8'h0D) begin n_err++; $display("FAIL dbz_clear got %h want 0d", uo_out); end
        rsel = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n;
        start_op(8'd100, 4'd3);
        n = 0;
        for (int i = 0; i < 40 && uio_out[6] === 1'b1; i++) begin
            n++;
            if (i == 4) begin
                ui_in = 8'd50;
                dvs   = 4'd5;
                start = 1'b1;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (n != 8) begin n_err++; $display("FAIL b2b_busy_cycles got %0d want 8", n); end
        n_cmp++;
        if (uo_out !== 8'd33) begin n_err++; $display("FAIL b2b_quot got %0d want 33", uo_out); end
        rsel = 1'b1;
        #1;
        n_cmp++;
        if (uo_out !== 8'h01) begin n_err++; $display("FAIL b2b_rem got %h want 01", uo_out); end
        rsel = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (uio_out !== 8'h80) begin n_err++; $display("FAIL held_start_status got %h want 80", uio_out); end
        n_cmp++;
        if (uo_out !== 8'd33) begin n_err++; $display("FAIL held_start_quot got %0d want 33", uo_out); end
        start = 1'b0;
    endtask

    task automatic test_lost_edge;
        @(negedge clk);
        ena   = 1'b0;
        ui_in = 8'd9;
        dvs   = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (uio_out !== 8'h80) begin n_err++; $display("FAIL lost_edge_status got %h want 80", uio_out); end
        n_cmp++;
        if (uo_out !== 8'd33) begin n_err++; $display("FAIL lost_edge_quot got %0d want 33", uo_out); end
    endtask

    task automatic test_ena_stall;
        int n;
        start_op(8'd200, 4'd7);
        n = 0;
        for (int i = 0; i < 40 && uio_out[6] === 1'b1; i++) begin
            n++;
            ena = !(i >= 3 && i < 6);
            @(negedge clk);
        end
        ena = 1'b1;
        n_cmp++;
        if (n != 11) begin n_err++; $display("FAIL stall_busy_cycles got %0d want 11", n); end
        n_cmp++;
        if (uio_out !== 8'h80) begin n_err++; $display("FAIL stall_done got %h want 80", uio_out); end
        n_cmp++;
        if (uo_out !== 8'd28) begin n_err++; $display("FAIL stall_quot got %0d want 28", uo_out); end
        rsel = 1'b1;
        #1;
        n_cmp++;
        if (uo_out !== 8'h04) begin n_err++; $display("FAIL stall_rem got %h want 04", uo_out); end
        rsel = 1'b0;
    endtask

    task automatic test_mid_reset;
        int n;
        start_op(8'd200, 4'd7);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (uio_out !== 8'h00) begin n_err++; $display("FAIL midrst_status got %h want 00", uio_out); end
        n_cmp++;
        if (uo_out !== 8'h00) begin n_err++; $display("FAIL midrst_quot got %h want 00", uo_out); end
        rsel = 1'b1;
        #1;
        n_cmp++;
        if (uo_out !== 8'h00) begin n_err++; $display("FAIL midrst_rem got %h want 00", uo_out); end
        rsel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (uio_out !== 8'h00) begin n_err++; $display("FAIL post_rst_idle got %h want 00", uio_out); end
        start_op(8'd200, 4'd7);
        wait_busy(n);
        n_cmp++;
        if (n != 8) begin n_err++; $display("FAIL fresh_busy_cycles got %0d want 8", n); end
        n_cmp++;
        if (uo_out !== 8'd28) begin n_err++; $display("FAIL fresh_quot got %0d want 28", uo_out); end
        rsel = 1'b1;
        #1;
        n_cmp++;
        if (uo_out !== 8'h04) begin n_err++; $display("FAIL fresh_rem got %h want 04", uo_out); end
        rsel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_division();
        test_div_by_zero();
        test_back_to_back();
        test_lost_edge();
        test_ena_stall();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tt_um_restoring_divider.md
TT_UM_RESTORING_DIVIDER -- requirements
Module: tt_um_restoring_divider

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  system clock, all state rises on posedge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  design enable; low freezes all state.
REQ-005 ui_in  input  8  unsigned dividend.
REQ-006 uio_in  input  8  bits [3:0] are the unsigned divisor, bit 4 is start, bit 5 is rsel (output select); bits [7:6] are ignored.
REQ-007 uo_out  output  8  quotient when rsel=0; {dbz,3'b000,remainder[3:0]} when rsel=1.
REQ-008 uio_out  output  8  bit 7 is done, bit 6 is busy, bits [5:0] are tied to 0.
REQ-009 uio_oe  output  8  SHALL be constant 8'b1100_0000.

Function
REQ-010 Operation SHALL be unsigned restoring division, 8-bit dividend by 4-bit divisor, one quotient bit per clk while ena=1.
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 Start detection SHALL be rising-edge (start high, registered start_q low); a held-high start SHALL NOT retrigger.
REQ-013 A start edge in IDLE or DONE SHALL capture the dividend and divisor, clear the remainder accumulator (5 bits) and the iteration counter (3 bits), clear done, and enter RUN on the capture edge E0.
REQ-014 Each RUN edge: acc = {acc[3:0], dividend MSB}, dividend shifts left; if acc >= divisor then acc -= divisor and the quotient LSB = 1, else the quotient LSB = 0.
REQ-015 After the 8th iteration (edge E8) the FSM SHALL enter DONE; busy SHALL be high exactly during RUN (8 cycles).
REQ-016 done SHALL be high in DONE and held until the next start edge or reset; the quotient and remainder registers SHALL hold their values in DONE.
REQ-017 A start edge during RUN SHALL be ignored; the operation in progress SHALL complete unaffected.
REQ-018 Divisor 0 SHALL set dbz=1 at E0 and SHALL produce quotient 8'hFF and remainder = dividend[3:0] at DONE with the same latency; dbz SHALL clear on the next start edge.
REQ-019 ena=0 SHALL freeze the FSM, counter, datapath and start_q; start edges seen while ena=0 SHALL be lost.
REQ-020 The uo_out output mux on rsel SHALL be combinational, with no added latency.
REQ-021 The remainder SHALL always be less than the divisor when the divisor is nonzero; the quotient SHALL equal floor(dividend/divisor).

Reset
REQ-022 rst_n low SHALL asynchronously force the state to IDLE and the counter, acc, quotient, remainder, dbz, start_q, done and busy to 0; uo_out SHALL then read 0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation, with no partial result visible after release.
REQ-024 After reset release, the first start edge SHALL behave as in IDLE.

Structure
REQ-025 A shared package SHALL hold the state enum (IDLE/RUN/DONE) and the constants DIVIDEND_W=8, DIVISOR_W=4 and ITERS=8.
REQ-026 The datapath and FSM SHALL live in one sub-module div_core (ports: clk, rst_n, en, start, dividend, divisor, quotient, remainder, dbz, busy, done).
REQ-027 tt_um_restoring_divider SHALL contain only the pin mapping, the rsel mux and the uio_oe tie-off.
REQ-028 Unused inputs SHALL be explicitly consumed to suppress lint warnings.

Verification
REQ-029 Apply ui_in=200, divisor=7 and pulse start -> busy high 8 cycles, then done=1, uo_out=28; with rsel=1, uo_out=8'h04.
REQ-030 Apply 255/1 and 7/9 -> results 255 r0 and 0 r7 respectively, each with done asserted 8 edges after capture.
REQ-031 Apply 5/0 -> done after 8 cycles, uo_out=8'hFF; with rsel=1, uo_out=8'h85 (dbz=1, remainder 5).
REQ-032 Apply 100/3, then pulse a second start with 50/5 at iteration 4 -> result 33 r1 unaffected; start held high after done -> no retrigger.
REQ-033 Assert rst_n low at iteration 5 of 200/7 -> busy=0, done=0, uo_out=0 immediately; a fresh 200/7 then yields 28 r4.
REQ-034 Drop ena for 3 cycles mid-RUN of 200/7 -> completion is delayed by 3 cycles and the result stays 28 r4.
